udma_adc_ts_gen: RTL
====================

UDMA_ADC_TS_GEN -- requirements
Module: udma_adc_ts_gen

Interface
REQ-001 SHALL have parameter TS_DATA_WIDTH, default 28, timestamp width.
REQ-002 SHALL have parameter TS_NUM_CHS, default 8, number of event channels.
REQ-003 SHALL have parameter PRESC_WIDTH, default 8, prescaler width.
REQ-004 SHALL have parameter MIN_GAP, default 16, minimum ts_clk_i cycles between emissions; legal range 4..255.
REQ-005 SHALL have port ts_clk_i  input  1  timestamp clock; all logic on its rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ts_en_i  input  1  counter/capture enable; quasi-static, ts_clk_i domain.
REQ-008 SHALL have port ts_clr_i  input  1  synchronous clear of counter and prescaler.
REQ-009 SHALL have port presc_i  input  PRESC_WIDTH  counter increments every presc_i+1 cycles.
REQ-010 SHALL have port evt_i  input  TS_NUM_CHS  per-channel event levels, ts_clk_i-synchronous; rising edge = event.
REQ-011 SHALL have port evt_mask_i  input  TS_NUM_CHS  1 = channel ignored.
REQ-012 SHALL have port ts_valid_o  output  TS_NUM_CHS  per-channel toggle; one transition = one timestamp.
REQ-013 SHALL have port ts_data_o  output  TS_DATA_WIDTH  timestamp of the most recent emission.
REQ-014 SHALL have port ts_cnt_o  output  TS_DATA_WIDTH  live counter value.
REQ-015 SHALL have port drop_o  output  TS_NUM_CHS  one-cycle pulse per channel on lost event.

Function
REQ-016 Prescaler SHALL count 0..presc_i while ts_en_i=1; on reaching presc_i it returns to 0 and ts_cnt increments by 1; presc_i=0 means increment every cycle.
REQ-017 ts_cnt SHALL wrap modulo 2^TS_DATA_WIDTH (all-ones -> 0) without flag.
REQ-018 ts_clr_i=1 SHALL zero ts_cnt and prescaler next edge, priority over increment; pending events unaffected.
REQ-019 ts_en_i=0 SHALL freeze ts_cnt and prescaler and ignore new rises; pending events still drain.
REQ-020 Edge detect SHALL register evt_i; rise[c] = evt_i[c] & ~evt_q[c] & ~evt_mask_i[c] & ts_en_i.
REQ-021 On rise[c] with pending[c]=0, SHALL set pending[c] and store ts_cnt value of that cycle (pre-increment) in per-channel slot[c].
REQ-022 On rise[c] with pending[c]=1 and channel c not emitted that cycle, SHALL pulse drop_o[c] for one cycle and keep slot[c] unchanged.
REQ-023 FSM states IDLE, HOLD; reset state IDLE.
REQ-024 IDLE with any pending: SHALL select channel by round-robin starting at pointer rr, then on same edge: ts_data_o<=slot[sel], invert ts_valid_o[sel], clear pending[sel], rr<=sel+1 (wrap to 0), gap<=MIN_GAP-1, go HOLD.
REQ-025 HOLD: gap decrements each cycle; at gap=0 SHALL go IDLE; no emission in HOLD.
REQ-026 At most one ts_valid_o bit SHALL toggle per cycle, and consecutive toggles SHALL be at least MIN_GAP cycles apart.
REQ-027 ts_data_o SHALL be stable from one emission until the next.
REQ-028 Rise on channel c in the cycle c is emitted: emission uses old slot[c]; new event SHALL set pending[c] and overwrite slot[c]; no drop.
REQ-029 Latency: rise sampled at edge N sets pending at N; earliest emission at edge N+1.
REQ-030 evt_mask_i applied to pending channels SHALL NOT cancel them.

Reset
REQ-031 rst_ni low SHALL asynchronously clear ts_cnt, prescaler, evt_q, pending, slots, ts_data_o, ts_valid_o, drop_o, gap, rr to 0 and FSM to IDLE.
REQ-032 Reset mid-HOLD SHALL discard all pending events; first post-reset emission requires a new rise.

Verification
REQ-033 presc_i=3, ts_en_i=1 from reset -> ts_cnt_o=1 after 4 cycles, =5 after 20.
REQ-034 Force ts_cnt to all-ones, presc_i=0 -> next cycle ts_cnt_o=0, no other side effect.
REQ-035 ts_cnt=100, rise on ch2 -> next edge ts_data_o=100, ts_valid_o[2] toggles 0->1, others stable.
REQ-036 Rises on ch1, ch5, ch6 same cycle at ts_cnt=40, MIN_GAP=16 -> toggles ch1, ch5, ch6 at cycles +1, +17, +33, ts_data_o=40 each.
REQ-037 Second rise on ch3 while pending[3]=1 and HOLD -> drop_o[3] single pulse, emitted value equals first timestamp.
REQ-038 rst_ni low for 1 cycle during HOLD with ch4 pending -> all outputs 0, ch4 never emitted.

Source files
------------

// File: rtl/udma_adc_ts_gen_if.sv
// Output bundle of the ADC timestamp generator: per-channel valid toggles,
// emitted timestamp, live counter and per-channel drop pulses.
interface udma_adc_ts_gen_if #(
  parameter int unsigned TS_DATA_WIDTH = 28,
  parameter int unsigned TS_NUM_CHS    = 8
);

  logic [TS_NUM_CHS-1:0]    ts_valid_o;
  logic [TS_DATA_WIDTH-1:0] ts_data_o;
  logic [TS_DATA_WIDTH-1:0] ts_cnt_o;
  logic [TS_NUM_CHS-1:0]    drop_o;

  modport master (
    output ts_valid_o,
    output ts_data_o,
    output ts_cnt_o,
    output drop_o
  );

  modport slave (
    input ts_valid_o,
    input ts_data_o,
    input ts_cnt_o,
    input drop_o
  );

endinterface

// File: rtl/udma_adc_ts_gen.sv
// Prescaled timestamp counter with per-channel rising-edge capture and a
// round-robin emitter that spaces valid toggles at least MIN_GAP cycles apart.
module udma_adc_ts_gen #(
  parameter int unsigned TS_DATA_WIDTH = 28,
  parameter int unsigned TS_NUM_CHS    = 8,
  parameter int unsigned PRESC_WIDTH   = 8,
  parameter int unsigned MIN_GAP       = 16
) (
  input  logic                   ts_clk_i,
  input  logic                   rst_ni,
  input  logic                   ts_en_i,
  input  logic                   ts_clr_i,
  input  logic [PRESC_WIDTH-1:0] presc_i,
  input  logic [TS_NUM_CHS-1:0]  evt_i,
  input  logic [TS_NUM_CHS-1:0]  evt_mask_i,
  udma_adc_ts_gen_if.master      ts_if
);

  localparam int unsigned ChW  = (TS_NUM_CHS > 1) ? $clog2(TS_NUM_CHS) : 1;
  localparam int unsigned GapW = 8;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                   state_q, state_d;
  logic [PRESC_WIDTH-1:0]   presc_q, presc_d;
  logic [TS_DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [TS_NUM_CHS-1:0]    evt_q;
  logic [TS_NUM_CHS-1:0]    pend_q, pend_d;
  logic [TS_DATA_WIDTH-1:0] slot_q [TS_NUM_CHS];
  logic [TS_DATA_WIDTH-1:0] data_q, data_d;
  logic [TS_NUM_CHS-1:0]    valid_q, valid_d;
  logic [TS_NUM_CHS-1:0]    drop_q, drop_d;
  logic [GapW-1:0]          gap_q, gap_d;
  logic [ChW-1:0]           rr_q, rr_d;

  logic [TS_NUM_CHS-1:0]    rise;
  logic [TS_NUM_CHS-1:0]    emit_vec;
  logic [TS_NUM_CHS-1:0]    capture;
  logic [ChW-1:0]           sel_idx;
  logic                     sel_found;

  // Prescaler and counter; clear wins over increment regardless of enable.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (ts_clr_i) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (ts_en_i) begin
      if (presc_q >= presc_i) begin
        presc_d = '0;
        cnt_d   = cnt_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Round-robin pick of the first pending channel at or after rr_q.
  always_comb begin : p_arb
    int unsigned idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < TS_NUM_CHS; i++) begin
      idx = (32'(rr_q) + i) % TS_NUM_CHS;
      if (!sel_found && pend_q[idx[ChW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = idx[ChW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    rr_d     = rr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    emit_vec = '0;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          emit_vec[sel_idx] = 1'b1;
          data_d            = slot_q[sel_idx];
          valid_d           = valid_q ^ emit_vec;
          rr_d              = (32'(sel_idx) == TS_NUM_CHS - 1) ? '0 : sel_idx + 1'b1;
          gap_d             = GapW'(MIN_GAP - 1);
          state_d           = StHold;
        end
      end
      StHold: begin
        // Leave one cycle early so toggles land exactly MIN_GAP apart.
        if (gap_q <= GapW'(1)) begin
          gap_d   = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A channel emitted this cycle may take a new event without dropping it.
  always_comb begin
    rise    = evt_i & ~evt_q & ~evt_mask_i & {TS_NUM_CHS{ts_en_i}};
    capture = rise & (~pend_q | emit_vec);
    pend_d  = (pend_q & ~emit_vec) | rise;
    drop_d  = rise & pend_q & ~emit_vec;
  end

  always_ff @(posedge ts_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      presc_q <= '0;
      cnt_q   <= '0;
      evt_q   <= '0;
      pend_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
      drop_q  <= '0;
      gap_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_i;
      pend_q  <= pend_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge ts_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < TS_NUM_CHS; c++) begin
        slot_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < TS_NUM_CHS; c++) begin
        if (capture[c]) begin
          slot_q[c] <= cnt_q;
        end
      end
    end
  end

  assign ts_if.ts_valid_o = valid_q;
  assign ts_if.ts_data_o  = data_q;
  assign ts_if.ts_cnt_o   = cnt_q;
  assign ts_if.drop_o     = drop_q;

endmodule
